imem_responder: RTL and testbench

//   Instruction-memory responder for the core's external fetch port (exIns_*).

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_array.sv | 34 +++
 rtl/imem_responder.sv | 118 +++++++++++
 tb/tb_imem_responder.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: NOP word,
// responder FSM states and a constant-evaluable ceil(log2) helper.
package imem_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/imem_array.sv
// 1R1W synchronous word RAM. Read data is registered and held until the next
// read; a write to the index being read on the same edge returns the old word.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Contents are never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!nrst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding fetch, LAT-cycle latency, one-cycle
// valid pulse. Optional address checking is enabled by defining IMEM_ADDR_CHK_EN.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int LAT   = 2
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          exIns_ren,
  input  logic [31:0]   exIns_addr,
  output logic          exIns_valid,
  output logic [31:0]   exIns_in,
  input  logic          ld_wen,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          busy
`ifdef IMEM_ADDR_CHK_EN
  ,
  output logic          exIns_err
`endif
);

  localparam int CW = clog2(LAT + 1);

  imem_state_e   r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [31:0]   r_addr;
  logic [31:0]   w_rd_addr;
  logic [AW-1:0] w_rd_idx;
  logic [31:0]   w_rdata;
  logic          w_accept;
  logic          w_enter_resp;

  assign w_accept = exIns_ren && (r_state != WAIT);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (LAT == 1) begin
            w_state_next = RESP;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = CW'(LAT - 1);
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        if (r_cnt == CW'(1)) w_state_next = RESP;
        else                 w_cnt_next   = r_cnt - CW'(1);
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) r_addr <= exIns_addr;
    end
  end

  // With LAT=1 the read happens on the accepting edge, before r_addr is loaded.
  assign w_enter_resp = (w_state_next == RESP);
  assign w_rd_addr    = w_accept ? exIns_addr : r_addr;
  assign w_rd_idx     = w_rd_addr[AW+1:2];

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .nrst    (nrst),
    .i_re    (w_enter_resp),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rdata),
    .i_we    (ld_wen),
    .i_waddr (ld_addr),
    .i_wdata (ld_wdata)
  );

  assign exIns_valid = (r_state == RESP);
  assign busy        = (r_state == WAIT);

`ifdef IMEM_ADDR_CHK_EN
  logic r_bad;
  logic w_bad;

  assign w_bad = (w_rd_addr[1:0] != 2'b00) || (w_rd_addr[31:2] >= 30'(DEPTH));

  // r_bad is held with the data so exIns_in stays stable after the pulse.
  always_ff @(posedge clk) begin
    if (!nrst)             r_bad <= 1'b0;
    else if (w_enter_resp) r_bad <= w_bad;
  end

  assign exIns_in  = r_bad ? NOP_INSN : w_rdata;
  assign exIns_err = r_bad && exIns_valid;
`else
  logic [31-AW:0] w_unused_addr;

  assign w_unused_addr = {w_rd_addr[31:AW+2], w_rd_addr[1:0]};
  assign exIns_in      = w_rdata;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (LAT=1,2,3) on shared stimulus,
// directed scenarios plus a random run against a cycle-count model; IMEM_ADDR_CHK_EN aware.
module tb_imem_responder;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ren;
  logic [31:0] addr;
  logic        ld_wen;
  logic [9:0]  ld_addr;
  logic [31:0] ld_wdata;

  logic        v_o  [NI];
  logic [31:0] in_o [NI];
  logic        b_o  [NI];
`ifdef IMEM_ADDR_CHK_EN
  logic        e_o  [NI];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    imem_responder #(
      .DEPTH (1024),
      .AW    (10),
      .LAT   (gi + 1)
    ) u_dut (
      .clk         (clk),
      .nrst        (nrst),
      .exIns_ren   (ren),
      .exIns_addr  (addr),
      .exIns_valid (v_o[gi]),
      .exIns_in    (in_o[gi]),
      .ld_wen      (ld_wen),
      .ld_addr     (ld_addr),
      .ld_wdata    (ld_wdata),
      .busy        (b_o[gi])
`ifdef IMEM_ADDR_CHK_EN
      ,
      .exIns_err   (e_o[gi])
`endif
    );
  end

  // Reference model: each instance has at most one pending fetch, due LAT
  // cycles after acceptance; its word is sampled one cycle before it is due.
  int          cyc = 0;
  bit          m_pend  [NI];
  int          m_due   [NI];
  logic [31:0] m_paddr [NI];
  logic [31:0] m_hold  [NI];
  logic [31:0] m_mem   [1024];
`ifdef IMEM_ADDR_CHK_EN
  bit          m_hbad  [NI];
`endif

  function automatic bit exp_v(input int k);
    return m_pend[k] && (m_due[k] == cyc);
  endfunction

  function automatic bit exp_b(input int k);
    return m_pend[k] && (m_due[k] > cyc);
  endfunction

  task automatic tick();
    for (int k = 0; k < NI; k++) begin
      if (!nrst) begin
        m_pend[k] = 1'b0;
        m_hold[k] = 32'h0;
`ifdef IMEM_ADDR_CHK_EN
        m_hbad[k] = 1'b0;
`endif
      end else begin
        if (m_pend[k] && m_due[k] == cyc) m_pend[k] = 1'b0;
        if (ren && !m_pend[k]) begin
          m_pend[k]  = 1'b1;
          m_due[k]   = cyc + k + 1;
          m_paddr[k] = addr;
        end
        if (m_pend[k] && m_due[k] == cyc + 1) begin
          m_hold[k] = m_mem[(m_paddr[k] >> 2) % 1024];
`ifdef IMEM_ADDR_CHK_EN
          m_hbad[k] = (m_paddr[k] % 4 != 0) || ((m_paddr[k] >> 2) >= 1024);
          if (m_hbad[k]) m_hold[k] = 32'h0000_0013;
`endif
        end
      end
    end
    if (ld_wen) m_mem[ld_addr] = ld_wdata;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    ren    = 1'b0;
    ld_wen = 1'b0;
    repeat (4) tick();
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    ld_wen   = 1'b1;
    ld_addr  = 10'(idx);
    ld_wdata = data;
    tick();
    ld_wen   = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) << 2;
    if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
    if ($urandom_range(0, 3) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 7));
    return a;
  endfunction

  task automatic test_reset();
    int first [NI];
    nrst = 1'b0;
    ren  = 1'b1;
    addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (v_o[k] !== 1'b0 || b_o[k] !== 1'b0 || in_o[k] !== 32'h0) begin
          errors++;
          $display("FAIL reset_hold lat=%0d: got v=%b busy=%b in=%h, want 0 0 00000000",
                   k + 1, v_o[k], b_o[k], in_o[k]);
        end
      end
    end
    nrst = 1'b1;
    for (int k = 0; k < NI; k++) first[k] = -1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      for (int k = 0; k < NI; k++)
        if (v_o[k] === 1'b1 && first[k] < 0) first[k] = i;
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (first[k] != k + 1) begin
        errors++;
        $display("FAIL reset_release lat=%0d: first valid after %0d cycles, want %0d",
                 k + 1, first[k], k + 1);
      end
    end
    drain();
  endtask

  task automatic test_basic();
    ren  = 1'b1;
    addr = 32'h4;
    tick();
    ren = 1'b0;
    checks++;
    if (v_o[1] !== 1'b0 || b_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL basic_t1: got v=%b busy=%b, want v=0 busy=1", v_o[1], b_o[1]);
    end
    tick();
    checks++;
    if (v_o[1] !== 1'b1 || in_o[1] !== 32'h0000_0013) begin
      errors++;
      $display("FAIL basic_t2: got v=%b in=%h, want v=1 in=00000013", v_o[1], in_o[1]);
    end
    tick();
    checks++;
    if (v_o[1] !== 1'b0 || in_o[1] !== 32'h0000_0013) begin
      errors++;
      $display("FAIL basic_t3: got v=%b in=%h, want v=0 in=00000013", v_o[1], in_o[1]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] expw [3];
    expw[0] = 32'h0050_0093;
    expw[1] = 32'h0000_0013;
    expw[2] = 32'h00A0_0113;
    for (int i = 0; i < 3; i++) begin
      ren  = 1'b1;
      addr = 32'(i * 4);
      tick();
      checks++;
      if (v_o[0] !== 1'b1 || in_o[0] !== expw[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got v=%b in=%h, want v=1 in=%h", i, v_o[0], in_o[0], expw[i]);
      end
    end
    ren = 1'b0;
    tick();
    checks++;
    if (v_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got v=%b, want 0", v_o[0]);
    end
    drain();
  endtask

  task automatic test_ignore_busy();
    int          pulses = 0;
    int          at     = -1;
    logic [31:0] got    = 32'h0;
    ren  = 1'b1;
    addr = 32'h0;
    tick();
    addr = 32'h8;
    for (int i = 1; i <= 6; i++) begin
      if (v_o[2] === 1'b1) begin
        pulses++;
        got = in_o[2];
        at  = i;
        ren = 1'b0;
      end
      tick();
    end
    checks++;
    if (pulses != 1 || at != 3 || got !== 32'h0050_0093) begin
      errors++;
      $display("FAIL ignore_busy: got pulses=%0d at=%0d data=%h, want 1 3 00500093",
               pulses, at, got);
    end
    drain();
  endtask

  task automatic test_collision();
    ren  = 1'b1;
    addr = 32'h4;
    tick();
    ren      = 1'b0;
    ld_wen   = 1'b1;
    ld_addr  = 10'd1;
    ld_wdata = 32'hDEAD_BEEF;
    tick();
    ld_wen = 1'b0;
    checks++;
    if (v_o[1] !== 1'b1 || in_o[1] !== 32'h0000_0013) begin
      errors++;
      $display("FAIL collision_old: got v=%b in=%h, want v=1 in=00000013", v_o[1], in_o[1]);
    end
    ren = 1'b1;
    tick();
    ren = 1'b0;
    tick();
    checks++;
    if (v_o[1] !== 1'b1 || in_o[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL collision_new: got v=%b in=%h, want v=1 in=deadbeef", v_o[1], in_o[1]);
    end
    drain();
  endtask

  task automatic test_reset_mid_wait();
    ren  = 1'b1;
    addr = 32'h0;
    tick();
    checks++;
    if (b_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL midwait_busy: got busy=%b, want 1", b_o[2]);
    end
    ren  = 1'b0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    checks++;
    if (in_o[2] !== 32'h0) begin
      errors++;
      $display("FAIL midwait_in: got in=%h, want 00000000", in_o[2]);
    end
    for (int i = 0; i < 5; i++) begin
      for (int k = 1; k < NI; k++) begin
        checks++;
        if (v_o[k] !== 1'b0 || b_o[k] !== 1'b0) begin
          errors++;
          $display("FAIL midwait_drop lat=%0d cyc=%0d: got v=%b busy=%b, want 0 0",
                   k + 1, cyc, v_o[k], b_o[k]);
        end
      end
      tick();
    end
  endtask

`ifdef IMEM_ADDR_CHK_EN
  task automatic test_range();
    logic [31:0] bad [2];
    bad[0] = 32'h2;
    bad[1] = 32'h1000;
    for (int i = 0; i < 2; i++) begin
      ren  = 1'b1;
      addr = bad[i];
      tick();
      ren = 1'b0;
      tick();
      checks++;
      if (v_o[1] !== 1'b1 || in_o[1] !== 32'h0000_0013 || e_o[1] !== 1'b1) begin
        errors++;
        $display("FAIL range_%h: got v=%b in=%h err=%b, want 1 00000013 1",
                 bad[i], v_o[1], in_o[1], e_o[1]);
      end
      tick();
      checks++;
      if (v_o[1] !== 1'b0 || e_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL range_after_%h: got v=%b err=%b, want 0 0", bad[i], v_o[1], e_o[1]);
      end
      drain();
    end
  endtask
`else
  task automatic test_wrap();
    ren  = 1'b1;
    addr = 32'h0000_1006;
    tick();
    ren = 1'b0;
    tick();
    checks++;
    if (v_o[1] !== 1'b1 || in_o[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wrap: got v=%b in=%h, want v=1 in=deadbeef", v_o[1], in_o[1]);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      nrst     = ($urandom_range(0, 49) != 0);
      ren      = ($urandom_range(0, 9) < 6);
      addr     = rand_addr();
      ld_wen   = ($urandom_range(0, 3) == 0);
      ld_addr  = 10'($urandom_range(0, 15));
      ld_wdata = $urandom;
      tick();
      for (int k = 0; k < NI; k++) begin
        checks++;
        if (v_o[k] !== exp_v(k) || in_o[k] !== m_hold[k] || b_o[k] !== exp_b(k)) begin
          errors++;
          $display("FAIL random lat=%0d cyc=%0d: got v=%b in=%h busy=%b, want v=%b in=%h busy=%b",
                   k + 1, cyc, v_o[k], in_o[k], b_o[k], exp_v(k), m_hold[k], exp_b(k));
        end
`ifdef IMEM_ADDR_CHK_EN
        checks++;
        if (e_o[k] !== (exp_v(k) && m_hbad[k])) begin
          errors++;
          $display("FAIL random_err lat=%0d cyc=%0d: got err=%b, want %b",
                   k + 1, cyc, e_o[k], exp_v(k) && m_hbad[k]);
        end
`endif
      end
      if (exp_v(1))
        $display("resp lat=2 cyc=%0d addr=%h data=%h", cyc, m_paddr[1], m_hold[1]);
    end
    nrst = 1'b1;
    drain();
  endtask

  initial begin
    nrst     = 1'b0;
    ren      = 1'b0;
    addr     = 32'h0;
    ld_wen   = 1'b0;
    ld_addr  = 10'd0;
    ld_wdata = 32'h0;
    for (int k = 0; k < NI; k++) begin
      m_pend[k]  = 1'b0;
      m_due[k]   = 0;
      m_paddr[k] = 32'h0;
      m_hold[k]  = 32'h0;
`ifdef IMEM_ADDR_CHK_EN
      m_hbad[k]  = 1'b0;
`endif
    end
    repeat (2) tick();
    nrst = 1'b1;
    load_word(0, 32'h0050_0093);
    load_word(1, 32'h0000_0013);
    load_word(2, 32'h00A0_0113);
    for (int i = 3; i < 16; i++) load_word(i, $urandom);

    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_collision();
    test_reset_mid_wait();
`ifdef IMEM_ADDR_CHK_EN
    test_range();
`else
    test_wrap();
`endif
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
